// File: rtl/mem_store_buffer.sv
// mem_store_buffer
//   Write-side store buffer for the MEM stage. Byte/halfword/word stores from
//   EX are encoded into {word address, byte enables, replicated data} and held
//   in a FIFO. The FIFO drains to the data SRAM port in any cycle where no load
//   requests the port. Loads that hit a buffered word raise ld_hazard/stallreq
//   until that word has drained.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   i_st_valid/op/addr/data store request from EX (op one-hot {sb, sh, sw})
//   o_st_ready             buffer not full
//   o_st_excp              misaligned store (address-error exception)
//   i_ld_valid, i_ld_addr  load requesting the SRAM port this cycle
//   o_ld_hazard            a buffered entry matches the load word
//   o_stallreq             pipeline stall request to CTRL
//   o_data_sram_*          drain port (all zero when not draining)
//   o_buf_empty, o_buf_count  occupancy
module mem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_st_valid,
  input  logic [2:0]                 i_st_op,
  input  logic [31:0]                i_st_addr,
  input  logic [31:0]                i_st_data,
  output logic                       o_st_ready,
  output logic                       o_st_excp,
  input  logic                       i_ld_valid,
  input  logic [31:0]                i_ld_addr,
  output logic                       o_ld_hazard,
  output logic                       o_stallreq,
  output logic                       o_data_sram_en,
  output logic [3:0]                 o_data_sram_wen,
  output logic [31:0]                o_data_sram_addr,
  output logic [31:0]                o_data_sram_wdata,
  output logic                       o_buf_empty,
  output logic [$clog2(DEPTH):0]     o_buf_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [29:0]   r_addr  [DEPTH];
  logic [3:0]    r_wen   [DEPTH];
  logic [31:0]   r_wdata [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_legal;
  logic          w_excp;
  logic [3:0]    w_enc_wen;
  logic [31:0]   w_enc_wdata;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_hit;
  logic [1:0]    w_a;

  assign w_a    = i_st_addr[1:0];
  assign w_full = (r_count == CW'(DEPTH));

  // Store encoding: byte enables, lane-replicated data and misalignment check.
  always_comb begin
    w_legal     = 1'b0;
    w_excp      = 1'b0;
    w_enc_wen   = 4'b0000;
    w_enc_wdata = 32'h0000_0000;
    case (i_st_op)
      3'b100: begin
        w_legal     = 1'b1;
        w_enc_wen   = 4'b0001 << w_a;
        w_enc_wdata = {4{i_st_data[7:0]}};
      end
      3'b010: begin
        w_legal     = 1'b1;
        w_excp      = i_st_valid & w_a[0];
        w_enc_wen   = w_a[1] ? 4'b1100 : 4'b0011;
        w_enc_wdata = {2{i_st_data[15:0]}};
      end
      3'b001: begin
        w_legal     = 1'b1;
        w_excp      = i_st_valid & (w_a != 2'b00);
        w_enc_wen   = 4'b1111;
        w_enc_wdata = i_st_data;
      end
      default: begin
        w_legal     = 1'b0;
        w_excp      = 1'b0;
        w_enc_wen   = 4'b0000;
        w_enc_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Push uses the current count only, so a full buffer refuses even if it pops now.
  assign w_push = i_st_valid & ~w_full & ~w_excp & w_legal;
  // Loads own the SRAM port unconditionally.
  assign w_pop  = (r_count != CW'(0)) & ~i_ld_valid;

  // Full-word match of the load against every valid entry; byte enables are ignored.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == i_ld_addr[31:2])) begin
        w_hit = 1'b1;
      end else begin
        w_hit = w_hit;
      end
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_push) begin
        r_addr[r_tail]  <= i_st_addr[31:2];
        r_wen[r_tail]   <= w_enc_wen;
        r_wdata[r_tail] <= w_enc_wdata;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      // When both happen, head != tail (push needs not-full, pop needs not-empty).
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Drain port is driven from the head entry only while popping.
  always_comb begin
    if (w_pop) begin
      o_data_sram_en    = 1'b1;
      o_data_sram_wen   = r_wen[r_head];
      o_data_sram_addr  = {r_addr[r_head], 2'b00};
      o_data_sram_wdata = r_wdata[r_head];
    end else begin
      o_data_sram_en    = 1'b0;
      o_data_sram_wen   = 4'b0000;
      o_data_sram_addr  = 32'h0000_0000;
      o_data_sram_wdata = 32'h0000_0000;
    end
  end

  assign o_st_ready  = ~w_full;
  assign o_st_excp   = w_excp;
  assign o_ld_hazard = i_ld_valid & w_hit;
  assign o_stallreq  = o_ld_hazard | (i_st_valid & w_full);
  assign o_buf_empty = (r_count == CW'(0));
  assign o_buf_count = r_count;

endmodule

// File: tb/tb_mem_store_buffer.sv
module tb_mem_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [2:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        st_excp;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        stallreq;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        buf_empty;
  logic [2:0]  buf_count;

  mem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_st_valid(st_valid), .i_st_op(st_op), .i_st_addr(st_addr), .i_st_data(st_data),
    .o_st_ready(st_ready), .o_st_excp(st_excp),
    .i_ld_valid(ld_valid), .i_ld_addr(ld_addr),
    .o_ld_hazard(ld_hazard), .o_stallreq(stallreq),
    .o_data_sram_en(sram_en), .o_data_sram_wen(sram_wen),
    .o_data_sram_addr(sram_addr), .o_data_sram_wdata(sram_wdata),
    .o_buf_empty(buf_empty), .o_buf_count(buf_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] SB = 3'b100;
  localparam logic [2:0] SH = 3'b010;
  localparam logic [2:0] SW = 3'b001;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        excp;
    logic [3:0]  wen;    // 0 means "must not be enqueued"
    logic [31:0] wdata;
  } vec_t;

  typedef struct {
    logic [29:0] a;
    logic [3:0]  w;
    logic [31:0] d;
  } ent_t;

  vec_t vt[12];
  ent_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    st_valid = 1'b0; st_op = 3'b000; st_addr = 32'h0; st_data = 32'h0;
    ld_valid = 1'b0; ld_addr = 32'h0;
  endtask

  task automatic store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_op = op; st_addr = a; st_data = d;
  endtask

  task automatic chk_drain(input string nm, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    chk({nm, "_en"}, {31'h0, sram_en}, 32'h1);
    chk({nm, "_addr"}, sram_addr, a);
    chk({nm, "_wen"}, {28'h0, sram_wen}, {28'h0, w});
    chk({nm, "_wdata"}, sram_wdata, d);
  endtask

  // Reference encoding from the byte-lane rules, written as plain arithmetic.
  function automatic logic [3:0] ref_wen(input logic [2:0] op, input logic [1:0] a);
    if (op == SB) return 4'(1 << a);
    if (op == SH) return (a >= 2'd2) ? 4'd12 : 4'd3;
    if (op == SW) return 4'd15;
    return 4'd0;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] d);
    if (op == SB) return {24'h0, d[7:0]} * 32'h0101_0101;
    if (op == SH) return {16'h0, d[15:0]} * 32'h0001_0001;
    if (op == SW) return d;
    return 32'h0;
  endfunction

  initial begin
    vt[0]  = '{SB, 32'h0000_1003, 32'h0000_00AB, 1'b0, 4'b1000, 32'hABAB_ABAB};
    vt[1]  = '{SH, 32'h0000_1002, 32'h0000_1234, 1'b0, 4'b1100, 32'h1234_1234};
    vt[2]  = '{SW, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'hDEAD_BEEF};
    vt[3]  = '{SB, 32'h0000_1000, 32'h1111_2233, 1'b0, 4'b0001, 32'h3333_3333};
    vt[4]  = '{SB, 32'h0000_1001, 32'hFFFF_FF5A, 1'b0, 4'b0010, 32'h5A5A_5A5A};
    vt[5]  = '{SB, 32'h0000_1006, 32'h0000_00C3, 1'b0, 4'b0100, 32'hC3C3_C3C3};
    vt[6]  = '{SH, 32'h0000_2000, 32'hAAAA_BEEF, 1'b0, 4'b0011, 32'hBEEF_BEEF};
    vt[7]  = '{SH, 32'h0000_2001, 32'h0000_1234, 1'b1, 4'b0000, 32'h0};
    vt[8]  = '{SW, 32'h0000_2002, 32'h0000_1234, 1'b1, 4'b0000, 32'h0};
    vt[9]  = '{SH, 32'h0000_2003, 32'h0000_1234, 1'b1, 4'b0000, 32'h0};
    vt[10] = '{3'b110, 32'h0000_2000, 32'h0000_1234, 1'b0, 4'b0000, 32'h0};
    vt[11] = '{3'b000, 32'h0000_2001, 32'h0000_1234, 1'b0, 4'b0000, 32'h0};

    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #3;
    // Reset state
    chk("rst_ready", {31'h0, st_ready}, 32'h1);
    chk("rst_empty", {31'h0, buf_empty}, 32'h1);
    chk("rst_count", {29'h0, buf_count}, 32'h0);
    chk("rst_en", {31'h0, sram_en}, 32'h0);
    chk("rst_addr", sram_addr, 32'h0);
    chk("rst_stall", {31'h0, stallreq}, 32'h0);
    chk("rst_haz", {31'h0, ld_hazard}, 32'h0);
    tick();

    // Table-driven single-store encoding / misalignment / illegal-op vectors
    for (int i = 0; i < 12; i++) begin
      store(vt[i].op, vt[i].addr, vt[i].data);
      #3;
      chk($sformatf("v%0d_excp", i), {31'h0, st_excp}, {31'h0, vt[i].excp});
      chk($sformatf("v%0d_nobypass", i), {31'h0, sram_en}, 32'h0);
      tick();
      idle();
      #3;
      if (vt[i].wen != 4'b0000) begin
        chk_drain($sformatf("v%0d", i), {vt[i].addr[31:2], 2'b00}, vt[i].wen, vt[i].wdata);
      end else begin
        chk($sformatf("v%0d_noenq_cnt", i), {29'h0, buf_count}, 32'h0);
        chk($sformatf("v%0d_noenq_en", i), {31'h0, sram_en}, 32'h0);
      end
      tick();
    end

    // Back-to-back encoding sequence held behind a load, then drained in order
    ld_valid = 1'b1; ld_addr = 32'h0000_F000;
    for (int i = 0; i < 3; i++) begin
      store(vt[i].op, vt[i].addr, vt[i].data);
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      #3;
      chk_drain($sformatf("seq%0d", i), 32'h0000_1000, vt[i].wen, vt[i].wdata);
      tick();
    end
    #3;
    chk("seq_empty", {31'h0, buf_empty}, 32'h1);
    tick();

    // Full and pointer wrap, two rounds
    for (int r = 0; r < 2; r++) begin
      ld_valid = 1'b1; ld_addr = 32'h0000_F000;
      for (int i = 0; i < 4; i++) begin
        store(SW, 32'h0000_5000 + 32'(16 * r + 4 * i), 32'(100 * r + i));
        tick();
      end
      store(SW, 32'h0000_5FF0, 32'h0000_0BAD);
      #3;
      chk($sformatf("full%0d_count", r), {29'h0, buf_count}, 32'd4);
      chk($sformatf("full%0d_ready", r), {31'h0, st_ready}, 32'h0);
      chk($sformatf("full%0d_stall", r), {31'h0, stallreq}, 32'h1);
      tick();
      idle();
      #3;
      chk($sformatf("full%0d_refused", r), {29'h0, buf_count}, 32'd4);
      for (int i = 0; i < 4; i++) begin
        chk_drain($sformatf("wrap%0d_%0d", r, i), 32'h0000_5000 + 32'(16 * r + 4 * i), 4'hF, 32'(100 * r + i));
        tick();
        #3;
      end
      chk($sformatf("wrap%0d_empty", r), {31'h0, buf_empty}, 32'h1);
      tick();
    end

    // Load hazard
    ld_valid = 1'b1; ld_addr = 32'h0000_3006;
    store(SW, 32'h0000_3004, 32'h0000_7777);
    tick();
    st_valid = 1'b0;
    #3;
    chk("haz_hit", {31'h0, ld_hazard}, 32'h1);
    chk("haz_stall", {31'h0, stallreq}, 32'h1);
    ld_addr = 32'h0000_3008;
    #1;
    chk("haz_other_word", {31'h0, ld_hazard}, 32'h0);
    ld_valid = 1'b0;
    #1;
    chk_drain("haz_drain", 32'h0000_3004, 4'hF, 32'h0000_7777);
    tick();
    ld_valid = 1'b1; ld_addr = 32'h0000_3006;
    #3;
    chk("haz_cleared", {31'h0, ld_hazard}, 32'h0);
    idle();
    tick();

    // Simultaneous push and pop at count 2
    ld_valid = 1'b1;
    store(SW, 32'h0000_6000, 32'hA0);
    tick();
    store(SW, 32'h0000_6004, 32'hA1);
    tick();
    ld_valid = 1'b0;
    store(SW, 32'h0000_6008, 32'hA2);
    #3;
    chk_drain("sim_head", 32'h0000_6000, 4'hF, 32'hA0);
    tick();
    idle();
    #3;
    chk("sim_count", {29'h0, buf_count}, 32'd2);
    chk_drain("sim_next", 32'h0000_6004, 4'hF, 32'hA1);
    tick(); tick();
    #3;
    chk("sim_empty", {31'h0, buf_empty}, 32'h1);

    // Reset mid-operation discards entries
    ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      store(SW, 32'h0000_7000 + 32'(4 * i), 32'(i));
      tick();
    end
    idle();
    ld_valid = 1'b1;
    #3;
    chk("mrst_pre", {29'h0, buf_count}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ld_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk($sformatf("mrst_count%0d", i), {29'h0, buf_count}, 32'h0);
      chk($sformatf("mrst_empty%0d", i), {31'h0, buf_empty}, 32'h1);
      chk($sformatf("mrst_en%0d", i), {31'h0, sram_en}, 32'h0);
      tick();
    end

    // Randomised run against a queue-based reference model
    q.delete();
    for (int c = 0; c < 1500; c++) begin
      logic        e_legal, e_excp, e_ready, e_push, e_haz, e_drain, e_rst;
      logic [1:0]  a;
      e_rst    = ($urandom_range(0, 199) == 0);
      rst      = e_rst;
      st_valid = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 9))
        0, 1, 2: st_op = SB;
        3, 4, 5: st_op = SH;
        6, 7, 8: st_op = SW;
        default: st_op = 3'($urandom);
      endcase
      st_addr  = 32'h0000_4000 + 32'($urandom_range(0, 23));
      st_data  = $urandom;
      ld_valid = ($urandom_range(0, 99) < 40);
      ld_addr  = 32'h0000_4000 + 32'($urandom_range(0, 23));
      a        = st_addr[1:0];
      e_legal  = (st_op == SB) || (st_op == SH) || (st_op == SW);
      e_excp   = st_valid && (((st_op == SH) && (a % 2 == 1)) || ((st_op == SW) && (a != 0)));
      e_ready  = (q.size() < DEPTH);
      e_push   = st_valid && e_ready && e_legal && !e_excp;
      e_haz    = 1'b0;
      foreach (q[k]) if (q[k].a == ld_addr[31:2]) e_haz = 1'b1;
      e_haz    = e_haz && ld_valid;
      e_drain  = (q.size() > 0) && !ld_valid;
      #3;
      chk("rnd_excp", {31'h0, st_excp}, {31'h0, e_excp});
      chk("rnd_ready", {31'h0, st_ready}, {31'h0, e_ready});
      chk("rnd_haz", {31'h0, ld_hazard}, {31'h0, e_haz});
      chk("rnd_stall", {31'h0, stallreq}, {31'h0, e_haz || (st_valid && !e_ready)});
      chk("rnd_count", {29'h0, buf_count}, 32'(q.size()));
      chk("rnd_en", {31'h0, sram_en}, {31'h0, e_drain});
      if (e_drain) begin
        chk("rnd_addr", sram_addr, {q[0].a, 2'b00});
        chk("rnd_wen", {28'h0, sram_wen}, {28'h0, q[0].w});
        chk("rnd_wdata", sram_wdata, q[0].d);
      end else begin
        chk("rnd_idle_bus", sram_addr | sram_wdata | {28'h0, sram_wen}, 32'h0);
      end
      tick();
      if (e_rst) begin
        q.delete();
      end else begin
        if (e_drain) void'(q.pop_front());
        if (e_push) q.push_back('{st_addr[31:2], ref_wen(st_op, a), ref_wdata(st_op, st_data)});
      end
    end
    rst = 1'b0;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
